// File: rtl/router_16port.sv
// 16x16 serial packet router: a decoder per input port plus a
// fixed-priority crossbar with registered outputs.

// Per-input decoder: assembles the destination address from the frame
// head, pads, then hands data to the crossbar or drops the frame.
module router_port #(
  parameter int ADDR_W     = 4,
  parameter int PAD_CYCLES = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              din,
  input  logic              frame_n,
  input  logic              grant,
  output logic              req,
  output logic [ADDR_W-1:0] req_addr,
  output logic              own_vld,
  output logic              own_data,
  output logic [ADDR_W-1:0] own_addr,
  output logic              busy_n
);
  localparam int CW = ($clog2(PAD_CYCLES) > $clog2(ADDR_W)) ?
                      $clog2(PAD_CYCLES) : $clog2(ADDR_W);

  typedef enum logic [2:0] {IDLE, ADDR, PAD, DATA, DROP} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy_n;

  // Request is raised in the cycle carrying the last address bit so the
  // grant decision lands on the same edge that enters PAD/DROP.
  assign req      = (r_state == ADDR) && (r_cnt == CW'(ADDR_W-1)) && !frame_n;
  assign req_addr = r_addr | (ADDR_W'(din) << (ADDR_W-1));
  assign own_vld  = (r_state == PAD) || (r_state == DATA);
  assign own_data = (r_state == DATA);
  assign own_addr = r_addr;
  assign busy_n   = r_busy_n;

  // Frame decode state machine; frame_n high aborts any non-idle phase.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_busy_n <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (!frame_n) begin
          r_addr  <= ADDR_W'(din);
          r_cnt   <= CW'(1);
          r_state <= ADDR;
        end
        ADDR: if (frame_n) begin
          r_state <= IDLE;
        end else begin
          r_addr <= r_addr | (ADDR_W'(din) << r_cnt);
          if (r_cnt == CW'(ADDR_W-1)) begin
            r_cnt <= '0;
            if (grant) r_state <= PAD;
            else begin
              r_state  <= DROP;
              r_busy_n <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        PAD: if (frame_n) r_state <= IDLE;
             else if (r_cnt == CW'(PAD_CYCLES-1)) r_state <= DATA;
             else r_cnt <= r_cnt + CW'(1);
        DATA: if (frame_n) r_state <= IDLE;
        DROP: if (frame_n) begin
          r_state  <= IDLE;
          r_busy_n <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

module router_16port #(
  parameter int NPORTS     = 16,
  parameter int ADDR_W     = 4,
  parameter int PAD_CYCLES = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NPORTS-1:0] din,
  input  logic [NPORTS-1:0] frame_n,
  input  logic [NPORTS-1:0] valid_n,
  output logic [NPORTS-1:0] dout,
  output logic [NPORTS-1:0] frameo_n,
  output logic [NPORTS-1:0] valido_n,
  output logic [NPORTS-1:0] busy_n
);
  logic [NPORTS-1:0]             w_req, w_grant, w_own_vld, w_own_data;
  logic [NPORTS-1:0][ADDR_W-1:0] w_req_addr, w_own_addr, w_src;
  logic [NPORTS-1:0]             w_owned, w_taken, w_src_vld;
  logic [NPORTS-1:0]             r_dout, r_frameo_n, r_valido_n;

  genvar g;
  generate
    for (g = 0; g < NPORTS; g++) begin : g_port
      router_port #(.ADDR_W(ADDR_W), .PAD_CYCLES(PAD_CYCLES)) u_port (
        .clk      (clk),
        .reset_n  (reset_n),
        .din      (din[g]),
        .frame_n  (frame_n[g]),
        .grant    (w_grant[g]),
        .req      (w_req[g]),
        .req_addr (w_req_addr[g]),
        .own_vld  (w_own_vld[g]),
        .own_data (w_own_data[g]),
        .own_addr (w_own_addr[g]),
        .busy_n   (busy_n[g])
      );
    end
  endgenerate

  // Ownership map from decoder state; grants walk inputs in ascending
  // order so the lowest requester claims a free output first.
  always_comb begin
    w_owned   = '0;
    w_src_vld = '0;
    w_src     = '0;
    w_grant   = '0;
    for (int j = 0; j < NPORTS; j++) begin
      if (w_own_vld[j]) w_owned[w_own_addr[j]] = 1'b1;
      if (w_own_data[j]) begin
        w_src_vld[w_own_addr[j]] = 1'b1;
        w_src[w_own_addr[j]]     = ADDR_W'(j);
      end
    end
    w_taken = w_owned;
    for (int i = 0; i < NPORTS; i++) begin
      if (w_req[i] && !w_taken[w_req_addr[i]]) begin
        w_grant[i]              = 1'b1;
        w_taken[w_req_addr[i]]  = 1'b1;
      end
    end
  end

  // Output registers: forward the owning input in DATA, else idle levels.
  always_ff @(posedge clk) begin
    for (int a = 0; a < NPORTS; a++) begin
      if (reset_n || !w_src_vld[a]) begin
        r_dout[a]     <= 1'b0;
        r_frameo_n[a] <= 1'b1;
        r_valido_n[a] <= 1'b1;
      end else begin
        r_dout[a]     <= din[w_src[a]];
        r_frameo_n[a] <= frame_n[w_src[a]];
        r_valido_n[a] <= valid_n[w_src[a]];
      end
    end
  end

  assign dout     = r_dout;
  assign frameo_n = r_frameo_n;
  assign valido_n = r_valido_n;
endmodule

// File: tb/tb_router_16port.sv
// Directed scenarios plus random traffic, every cycle compared against a
// frame-position reference model of the router.
module tb_router_16port;
  localparam int NP  = 16;
  localparam int PAD = 5;
  localparam int DAT = 4 + PAD;   // frame cycle index of the first data bit

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0] din, frame_n, valid_n;
  logic [NP-1:0] dout, frameo_n, valido_n, busy_n;

  int checks = 0;
  int errors = 0;

  // per-port stimulus queue of {frame_n, din, valid_n}
  logic [2:0] q [NP][$];

  // reference model: position within the current frame, drop flag,
  // assembled address, owner per output (-1 free)
  int         pos   [NP];
  bit         drop  [NP];
  logic [3:0] acc   [NP];
  int         owner [NP];
  logic [NP-1:0] e_dout, e_fo, e_vo, e_busy;

  router_16port dut (
    .clk(clk), .reset_n(rst), .din(din), .frame_n(frame_n), .valid_n(valid_n),
    .dout(dout), .frameo_n(frameo_n), .valido_n(valido_n), .busy_n(busy_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      pos[i] = -1; drop[i] = 0; acc[i] = '0; owner[i] = -1;
    end
    e_dout = '0; e_fo = '1; e_vo = '1; e_busy = '1;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int own0 [NP];
    bit taken [NP];
    int a;
    if (rst) begin model_reset(); return; end
    for (int o = 0; o < NP; o++) begin
      own0[o] = owner[o];
      taken[o] = 0;
      if (own0[o] >= 0 && pos[own0[o]] >= DAT) begin
        e_dout[o] = din[own0[o]];
        e_fo[o]   = frame_n[own0[o]];
        e_vo[o]   = valid_n[own0[o]];
      end else begin
        e_dout[o] = 1'b0; e_fo[o] = 1'b1; e_vo[o] = 1'b1;
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (drop[i]) begin
        if (frame_n[i]) drop[i] = 0;
      end else if (pos[i] < 0) begin
        if (!frame_n[i]) begin acc[i] = {3'b0, din[i]}; pos[i] = 1; end
      end else if (pos[i] <= 3) begin
        if (frame_n[i]) pos[i] = -1;
        else begin
          acc[i][pos[i]] = din[i];
          if (pos[i] == 3) begin
            a = int'(acc[i]);
            if (own0[a] < 0 && !taken[a]) begin
              taken[a] = 1; owner[a] = i; pos[i] = 4;
            end else begin
              drop[i] = 1; pos[i] = -1;
            end
          end else pos[i]++;
        end
      end else begin
        if (frame_n[i]) begin owner[int'(acc[i])] = -1; pos[i] = -1; end
        else pos[i]++;
      end
      e_busy[i] = !drop[i];
    end
  endtask

  task automatic step();
    logic [2:0] e;
    for (int p = 0; p < NP; p++) begin
      if (q[p].size() > 0) e = q[p].pop_front();
      else e = {1'b1, 1'($urandom), 1'b1};
      frame_n[p] = e[2]; din[p] = e[1]; valid_n[p] = e[0];
    end
    model_step();
    @(posedge clk); #1;
    chk("dout", dout, e_dout);
    chk("frameo_n", frameo_n, e_fo);
    chk("valido_n", valido_n, e_vo);
    chk("busy_n", busy_n, e_busy);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  function automatic bit any_queued();
    for (int p = 0; p < NP; p++) if (q[p].size() > 0) return 1;
    return 0;
  endfunction

  task automatic drain();
    for (int k = 0; k < 200 && any_queued(); k++) step();
    run(2);
  endtask

  // Full frame: 4 address bits, PAD filler cycles, ndata data bits with
  // frame_n high on the last one.
  task automatic frame(input int p, input logic [3:0] addr, input int ndata,
                       input logic [15:0] data, input bit rndv);
    for (int k = 0; k < 4; k++) q[p].push_back({1'b0, addr[k], 1'($urandom)});
    for (int k = 0; k < PAD; k++) q[p].push_back({1'b0, 1'($urandom), 1'($urandom)});
    for (int k = 0; k < ndata; k++)
      q[p].push_back({(k == ndata-1), data[k], rndv ? 1'($urandom) : 1'b0});
  endtask

  // Frame whose frame_n rises after nlow cycles (address or pad abort).
  task automatic short_frame(input int p, input int nlow);
    for (int k = 0; k < nlow; k++) q[p].push_back({1'b0, 1'($urandom), 1'($urandom)});
    q[p].push_back({1'b1, 1'($urandom), 1'($urandom)});
  endtask

  initial begin
    int r;
    din = '0; frame_n = '1; valid_n = '1; rst = 1'b1;
    model_reset();

    // reset held with ports 0..3 framing
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 5; k++) q[p].push_back({1'b0, 1'($urandom), 1'b0});
    run(5);
    chk("rst_frameo", frameo_n, 16'hFFFF);
    chk("rst_busy", busy_n, 16'hFFFF);
    rst = 1'b0;
    run(3);

    // port 0 -> output 5, data 1,0,1,1
    frame(0, 4'd5, 4, 16'b1101, 0);
    drain();
    chk("after5_frameo", frameo_n, 16'hFFFF);

    // ports 0 and 3 contend for output 9
    frame(0, 4'd9, 6, 16'h2D, 0);
    frame(3, 4'd9, 3, 16'h5, 0);
    run(6);
    chk("busy3_low", {15'h0, busy_n[3]}, 16'h0);
    drain();

    // port 1 hits output 2 owned by port 4, then retries after release
    frame(4, 4'd2, 8, 16'hA7, 0);
    run(2);
    frame(1, 4'd2, 1, 16'h1, 0);
    run(5);
    chk("busy1_low", {15'h0, busy_n[1]}, 16'h0);
    drain();
    frame(1, 4'd2, 3, 16'h6, 0);
    drain();

    // port 2 aborts after 2 address bits
    short_frame(2, 2);
    drain();

    // reset mid-DATA on port 0, then a fresh frame
    frame(0, 4'd7, 6, 16'h3B, 0);
    run(DAT + 2);
    rst = 1'b1;
    q[0].delete();
    run(1);
    rst = 1'b0;
    chk("midrst_frameo", frameo_n, 16'hFFFF);
    frame(0, 4'd7, 3, 16'h5, 0);
    drain();

    // random traffic, addresses biased to a few outputs for contention
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (q[p].size() == 0 && $urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 99);
          if (r < 70)
            frame(p, ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom),
                  $urandom_range(1, 6), 16'($urandom), 1);
          else if (r < 85) short_frame(p, $urandom_range(1, 3));
          else short_frame(p, $urandom_range(4, 8));
        end
      end
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_16port.md
Name: router_16port

Overview:
- 16-input, 16-output serial packet router.
- Each input port carries one serial bit stream (din) framed by active-low frame_n and qualified by active-low valid_n.
- A per-port decode sub-block extracts a 4-bit destination address from each frame's head and raises a request. A crossbar with fixed-priority arbitration then forwards the frame's bits to the addressed output port.
- Sits between the network ingress serializers and the egress deserializers.

Parameters:
- NPORTS, 16, number of input and output ports (must be 16).
- ADDR_W, 4, destination address bits (log2 NPORTS).
- PAD_CYCLES, 5, pad cycles between the address field and the data field.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset_n  input  1  synchronous, active-high reset (the level 1 resets, despite the _n name).
- din  input  16  serial data, bit i belongs to input port i.
- frame_n  input  16  active-low frame, bit i per port; low for the whole packet.
- valid_n  input  16  active-low data-valid, bit i per port.
- dout  output  16  serial data per output port.
- frameo_n  output  16  active-low frame per output port.
- valido_n  output  16  active-low valid per output port.
- busy_n  output  16  active-low; bit i low while input i's frame is being dropped.

Behaviour:
- Reset (reset_n==1 at a clk edge):
  - All decoders go to IDLE; all grants are cleared.
  - Outputs: dout=0, frameo_n=16'hFFFF, valido_n=16'hFFFF, busy_n=16'hFFFF.
  - Applies even mid-frame; the in-flight frame is lost.
- Per-port decode FSM states: IDLE, ADDR, PAD, DATA, DROP.
  - IDLE: frame_n[i]==0 samples address bit0 = din[i] and goes to ADDR.
  - ADDR: samples bits 1..3 on the next 3 cycles, LSB first. valid_n is ignored during address cycles.
  - End of ADDR: after bit3 is sampled, request pulses for exactly one cycle with address held stable.
  - Early abort: if frame_n[i] rises before bit3, return to IDLE with no request.
- Arbitration, evaluated in the request cycle:
  - Output a is free if no other input owns it.
  - Multiple simultaneous requests for a free output: the lowest input index wins.
  - The winner owns output a and goes to PAD.
  - A loser, or a requester of an already-owned output, goes to DROP with busy_n[i]=0.
  - There is no queuing.
- PAD: lasts PAD_CYCLES cycles, then the port goes to DATA. Bits received during PAD are not forwarded.
- DATA: each cycle, the owned output registers the input with one-cycle latency:
  - dout[a] <= din[i]
  - valido_n[a] <= valid_n[i]
  - frameo_n[a] <= frame_n[i]
  - Frame end: the cycle in which frame_n[i] is sampled high carries the last bit if valid_n[i]==0. It is forwarded with frameo_n[a]=1, then the port goes to IDLE and output a is released. A new request can claim a on the following cycle.
- If frame_n rises during PAD: release the output, go to IDLE, emit nothing.
- DROP: busy_n[i]=0 until frame_n[i] is sampled high, then IDLE with busy_n[i]=1 next cycle. Nothing is forwarded.
- Unowned outputs drive dout=0, frameo_n=1, valido_n=1.
- Back-to-back frames: frame_n may go low again the cycle after its rising edge, and IDLE accepts it immediately.
- All outputs are registered; there is no combinational path from input to output.

Test Plan:
- Reset held 5 cycles with frame_n=16'hFFF0 and random din -> all outputs idle (dout=0, frameo_n=valido_n=busy_n=16'hFFFF); no request.
- Port 0 sends address bits 1,0,1,0 (a=5), 5 pad cycles, data 1,0,1,1 with valid_n=0, frame_n rising on the last bit -> dout[5] shows 1,0,1,1 starting 1 cycle after the first data bit; frameo_n[5] low for bits 1-3 and high on the last; output 5 free afterward.
- Ports 0 and 3 both address output 9 in the same cycle -> port 0 forwarded to output 9; busy_n[3]=0 until frame_n[3] rises; output 9 never shows port 3 data.
- Port 1 starts a frame to a=2 while port 4 owns output 2 -> busy_n[1]=0 and port 1 dropped; a port 1 frame to a=2 started after port 4's frame ends is forwarded normally.
- frame_n[2] rises after 2 address bits -> no request; all outputs stay idle.
- reset_n asserted mid-DATA on port 0 -> next cycle the addressed output is idle; a new frame after reset routes correctly.
